mario_obj_dma: RTL and testbench

Sprite-list DMA controller for the Mario Bros main CPU board. It replaces the Z80 DMA device. When the CPU raises the DMA RDY control bit (7E85H), the block:
- requests the Z80 bus;
- copies the sprite list from work RAM (6900H) into OBJ RAM (7000H–73FFH);
- releases the bus.

It sits between the misc control latch and the CPU bus multiplexer. While it holds the bus, its address and strobes feed the address decoder in place of the CPU's.

---
 rtl/mario_obj_dma_if.sv | 25 ++
 rtl/mario_obj_dma.sv | 153 +++++++++++++++
 tb/tb_mario_obj_dma.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mario_obj_dma_if.sv
// rtl/mario_obj_dma_if.sv - CPU-bus side of the sprite-list DMA (handshake, address, data, strobes)
interface mario_obj_dma_if;
  logic        I_DMA_RDY;
  logic        I_BUSACK_n;
  logic [7:0]  I_DB;
  logic        O_BUSRQ_n;
  logic        O_BUS_EN;
  logic [15:0] O_AB;
  logic [7:0]  O_DB;
  logic        O_MREQ_n;
  logic        O_RD_n;
  logic        O_WR_n;
  logic        O_BUSY;
  logic        O_DONE;

  modport master (
    input  I_DMA_RDY, I_BUSACK_n, I_DB,
    output O_BUSRQ_n, O_BUS_EN, O_AB, O_DB, O_MREQ_n, O_RD_n, O_WR_n, O_BUSY, O_DONE
  );

  modport slave (
    output I_DMA_RDY, I_BUSACK_n, I_DB,
    input  O_BUSRQ_n, O_BUS_EN, O_AB, O_DB, O_MREQ_n, O_RD_n, O_WR_n, O_BUSY, O_DONE
  );
endinterface

// File: rtl/mario_obj_dma.sv
// rtl/mario_obj_dma.sv - sprite-list DMA: takes the Z80 bus and copies work RAM into OBJ RAM
module mario_obj_dma #(
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter logic [15:0] DST_BASE = 16'h7000,
  parameter int unsigned LENGTH   = 384
) (
  input  logic            I_CLK,
  input  logic            I_RESET,
  input  logic            I_CE,
  mario_obj_dma_if.master bus
);
  localparam logic [8:0] LAST_IDX = 9'(LENGTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, RD1, RD2, WR1, WR2, REL} state_t;

  state_t      state, state_nx;
  logic [8:0]  idx, idx_nx;
  logic [7:0]  data, data_nx;
  logic        rdy_prev;
  logic        abort, abort_nx;
  logic        done_flag, done_flag_nx;

  logic        busrq_n, busrq_n_nx;
  logic        bus_en, bus_en_nx;
  logic [15:0] ab, ab_nx;
  logic [7:0]  db, db_nx;
  logic        mreq_n, mreq_n_nx;
  logic        rd_n, rd_n_nx;
  logic        wr_n, wr_n_nx;
  logic        busy, busy_nx;
  logic        done, done_nx;

  logic        rd_phase, wr_phase;

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    data_nx      = data;
    abort_nx     = abort;
    done_flag_nx = done_flag;
    done_nx      = 1'b0;

    // A dropped RDY during a byte is remembered so the byte can still finish.
    if ((state == RD1 || state == RD2 || state == WR1 || state == WR2) && !bus.I_DMA_RDY)
      abort_nx = 1'b1;

    case (state)
      IDLE: begin
        if (bus.I_DMA_RDY && !rdy_prev) begin
          state_nx     = REQ;
          idx_nx       = '0;
          abort_nx     = 1'b0;
          done_flag_nx = 1'b0;
        end
      end
      REQ: begin
        if (!bus.I_DMA_RDY)
          state_nx = REL;
        else if (!bus.I_BUSACK_n)
          state_nx = RD1;
      end
      RD1: state_nx = RD2;
      RD2: begin
        state_nx = WR1;
        data_nx  = bus.I_DB;
      end
      WR1: state_nx = WR2;
      WR2: begin
        // Completion outranks a simultaneous abort on the last byte.
        if (idx == LAST_IDX) begin
          state_nx     = REL;
          done_flag_nx = 1'b1;
        end else if (abort_nx) begin
          state_nx = REL;
        end else begin
          idx_nx   = idx + 9'd1;
          state_nx = RD1;
        end
      end
      REL: begin
        if (bus.I_BUSACK_n) begin
          state_nx = IDLE;
          done_nx  = done_flag;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    rd_phase   = (state_nx == RD1) || (state_nx == RD2);
    wr_phase   = (state_nx == WR1) || (state_nx == WR2);
    bus_en_nx  = rd_phase || wr_phase;
    busrq_n_nx = !((state_nx == REQ) || bus_en_nx);
    mreq_n_nx  = !bus_en_nx;
    rd_n_nx    = !rd_phase;
    wr_n_nx    = !(state_nx == WR2);
    busy_nx    = (state_nx != IDLE);
    ab_nx      = 16'h0000;
    db_nx      = 8'h00;
    if (rd_phase)
      ab_nx = SRC_BASE + {7'b0, idx_nx};
    if (wr_phase) begin
      ab_nx = DST_BASE + {7'b0, idx_nx};
      db_nx = data_nx;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state     <= IDLE;
      idx       <= '0;
      data      <= 8'h00;
      rdy_prev  <= 1'b0;
      abort     <= 1'b0;
      done_flag <= 1'b0;
      busrq_n   <= 1'b1;
      bus_en    <= 1'b0;
      ab        <= 16'h0000;
      db        <= 8'h00;
      mreq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (I_CE) begin
      state     <= state_nx;
      idx       <= idx_nx;
      data      <= data_nx;
      rdy_prev  <= bus.I_DMA_RDY;
      abort     <= abort_nx;
      done_flag <= done_flag_nx;
      busrq_n   <= busrq_n_nx;
      bus_en    <= bus_en_nx;
      ab        <= ab_nx;
      db        <= db_nx;
      mreq_n    <= mreq_n_nx;
      rd_n      <= rd_n_nx;
      wr_n      <= wr_n_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  assign bus.O_BUSRQ_n = busrq_n;
  assign bus.O_BUS_EN  = bus_en;
  assign bus.O_AB      = ab;
  assign bus.O_DB      = db;
  assign bus.O_MREQ_n  = mreq_n;
  assign bus.O_RD_n    = rd_n;
  assign bus.O_WR_n    = wr_n;
  assign bus.O_BUSY    = busy;
  assign bus.O_DONE    = done;
endmodule

// File: tb/tb_mario_obj_dma.sv
// tb/tb_mario_obj_dma.sv - scoreboard bench for the sprite-list DMA
module tb_mario_obj_dma;
  localparam logic [30:0] RST_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  bit   quarter = 1'b0;
  int   cyc = 0;

  int errors = 0;
  int checks = 0;

  mario_obj_dma_if bus ();
  mario_obj_dma_if bus1 ();

  mario_obj_dma dut (
    .I_CLK(clk), .I_RESET(rst), .I_CE(ce), .bus(bus)
  );

  mario_obj_dma #(.LENGTH(1)) dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_CE(ce), .bus(bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    ce = quarter ? (cyc % 4 == 0) : 1'b1;
  end

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h6900;
    return off[7:0] ^ 8'h5A;
  endfunction

  assign bus.I_DB  = !bus.O_RD_n  ? src_byte(bus.O_AB)  : 8'h00;
  assign bus1.I_DB = !bus1.O_RD_n ? src_byte(bus1.O_AB) : 8'h00;

  logic [30:0] vec0, vec1;
  assign vec0 = {bus.O_BUSRQ_n, bus.O_BUS_EN, bus.O_MREQ_n, bus.O_RD_n, bus.O_WR_n,
                 bus.O_BUSY, bus.O_DONE, bus.O_AB, bus.O_DB};
  assign vec1 = {bus1.O_BUSRQ_n, bus1.O_BUS_EN, bus1.O_MREQ_n, bus1.O_RD_n, bus1.O_WR_n,
                 bus1.O_BUSY, bus1.O_DONE, bus1.O_AB, bus1.O_DB};

  logic [23:0] q[$];

  int tick_cnt = 0, wr2_cnt = 0, done_cnt = 0, first_rd1 = -1, last_wr2 = -1;
  logic [15:0] max_rd_ab = 16'h0;
  logic [23:0] wr1_ad = 24'h0;
  int rd_ticks1 = 0, wr2_cnt1 = 0, done_cnt1 = 0;
  logic [15:0] rd_ab1 = 16'h0;
  logic [23:0] wr_last1 = 24'h0;

  logic last_ce = 1'b1, last_rst = 1'b1;
  logic [30:0] snap = '0;
  bit snap_valid = 1'b0;

  always @(posedge clk) begin
    last_ce  = ce;
    last_rst = rst;
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (snap_valid && !last_ce && !last_rst) begin
      checks++;
      if (vec0 !== snap) begin
        errors++;
        $error("FAIL frozen_on_non_ce observed=%0h expected=%0h", vec0, snap);
      end
    end
    snap = vec0;
    snap_valid = 1'b1;
    if (ce) begin
      tick_cnt++;
      if (bus.O_BUS_EN && !bus.O_RD_n) begin
        if (first_rd1 < 0) first_rd1 = tick_cnt;
        if (bus.O_AB > max_rd_ab) max_rd_ab = bus.O_AB;
      end
      if (bus.O_BUS_EN && bus.O_RD_n && bus.O_WR_n)
        wr1_ad = {bus.O_AB, bus.O_DB};
      if (bus.O_BUS_EN && !bus.O_WR_n) begin
        wr2_cnt++;
        last_wr2 = tick_cnt;
        checks++;
        if ({bus.O_AB, bus.O_DB} !== wr1_ad) begin
          errors++;
          $error("FAIL write_setup_stable observed=%0h expected=%0h", {bus.O_AB, bus.O_DB}, wr1_ad);
        end
        checks++;
        if ((q.size() > 0) !== 1'b1) begin
          errors++;
          $error("FAIL write_expected observed=%0h expected=%0h", q.size() > 0, 1'b1);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if ({bus.O_AB, bus.O_DB} !== e) begin
            errors++;
            $error("FAIL write_addr_data observed=%0h expected=%0h", {bus.O_AB, bus.O_DB}, e);
          end
        end
      end
      if (bus.O_DONE) done_cnt++;
      if (bus1.O_BUS_EN && !bus1.O_RD_n) begin
        rd_ticks1++;
        rd_ab1 = bus1.O_AB;
      end
      if (bus1.O_BUS_EN && !bus1.O_WR_n) begin
        wr2_cnt1++;
        wr_last1 = {bus1.O_AB, bus1.O_DB};
      end
      if (bus1.O_DONE) done_cnt1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    while (!ce) @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rq(input logic v, input int budget, input string tag);
    int k;
    k = 0;
    while (bus.O_BUSRQ_n !== v && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (bus.O_BUSRQ_n !== v) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, bus.O_BUSRQ_n, v);
    end
  endtask

  task automatic push_range(input int n);
    for (int i = 0; i < n; i++)
      q.push_back({16'h7000 + 16'(i), 8'(i) ^ 8'h5A});
  endtask

  task automatic full_transfer(input string tag);
    int d0;
    first_rd1 = -1;
    last_wr2  = -1;
    wr2_cnt   = 0;
    d0        = done_cnt;
    push_range(384);
    bus.I_DMA_RDY = 1'b1;
    tick();
    checks++;
    if (bus.O_BUSRQ_n !== 1'b0) begin
      errors++;
      $error("FAIL %s_busrq_latency observed=%0h expected=%0h", tag, bus.O_BUSRQ_n, 1'b0);
    end
    checks++;
    if (bus.O_BUSY !== 1'b1) begin
      errors++;
      $error("FAIL %s_busy_on_req observed=%0h expected=%0h", tag, bus.O_BUSY, 1'b1);
    end
    ticks(3);
    bus.I_BUSACK_n = 1'b0;
    tick();
    checks++;
    if ({bus.O_BUS_EN, bus.O_MREQ_n, bus.O_RD_n, bus.O_AB} !== {1'b1, 1'b0, 1'b0, 16'h6900}) begin
      errors++;
      $error("FAIL %s_rd1_after_ack observed=%0h expected=%0h", tag,
             {bus.O_BUS_EN, bus.O_MREQ_n, bus.O_RD_n, bus.O_AB}, {1'b1, 1'b0, 1'b0, 16'h6900});
    end
    wait_rq(1'b1, 2000, {tag, "_bus_release"});
    ticks(2);
    bus.I_BUSACK_n = 1'b1;
    ticks(4);
    checks++;
    if (wr2_cnt !== 384) begin
      errors++;
      $error("FAIL %s_wr2_count observed=%0h expected=%0h", tag, wr2_cnt, 384);
    end
    checks++;
    if ((done_cnt - d0) !== 1) begin
      errors++;
      $error("FAIL %s_done_pulses observed=%0h expected=%0h", tag, done_cnt - d0, 1);
    end
    checks++;
    if ((last_wr2 - first_rd1 + 1) !== 1536) begin
      errors++;
      $error("FAIL %s_span_ticks observed=%0h expected=%0h", tag, last_wr2 - first_rd1 + 1, 1536);
    end
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $error("FAIL %s_queue_drained observed=%0h expected=%0h", tag, q.size(), 0);
    end
    checks++;
    if (vec0 !== RST_VEC) begin
      errors++;
      $error("FAIL %s_idle_after observed=%0h expected=%0h", tag, vec0, RST_VEC);
    end
    bus.I_DMA_RDY = 1'b0;
    tick();
  endtask

  initial begin
    int k, d0;
    bit stayed;
    bus.I_DMA_RDY   = 1'b0;
    bus.I_BUSACK_n  = 1'b1;
    bus1.I_DMA_RDY  = 1'b0;
    bus1.I_BUSACK_n = 1'b1;

    rst = 1'b1;
    ticks(2);
    checks++;
    if (vec0 !== RST_VEC) begin
      errors++;
      $error("FAIL reset_outputs observed=%0h expected=%0h", vec0, RST_VEC);
    end
    checks++;
    if (vec1 !== RST_VEC) begin
      errors++;
      $error("FAIL reset_outputs_len1 observed=%0h expected=%0h", vec1, RST_VEC);
    end
    rst = 1'b0;
    tick();

    full_transfer("default");

    bus1.I_DMA_RDY = 1'b1;
    tick();
    checks++;
    if (bus1.O_BUSRQ_n !== 1'b0) begin
      errors++;
      $error("FAIL len1_busrq observed=%0h expected=%0h", bus1.O_BUSRQ_n, 1'b0);
    end
    tick();
    bus1.I_BUSACK_n = 1'b0;
    k = 0;
    tick();
    while (bus1.O_BUSRQ_n !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (bus1.O_BUSRQ_n !== 1'b1) begin
      errors++;
      $error("FAIL len1_release observed=%0h expected=%0h", bus1.O_BUSRQ_n, 1'b1);
    end
    bus1.I_BUSACK_n = 1'b1;
    ticks(4);
    checks++;
    if (rd_ticks1 !== 2) begin
      errors++;
      $error("FAIL len1_read_ticks observed=%0h expected=%0h", rd_ticks1, 2);
    end
    checks++;
    if (rd_ab1 !== 16'h6900) begin
      errors++;
      $error("FAIL len1_read_addr observed=%0h expected=%0h", rd_ab1, 16'h6900);
    end
    checks++;
    if (wr2_cnt1 !== 1) begin
      errors++;
      $error("FAIL len1_write_count observed=%0h expected=%0h", wr2_cnt1, 1);
    end
    checks++;
    if (wr_last1 !== {16'h7000, 8'h5A}) begin
      errors++;
      $error("FAIL len1_write observed=%0h expected=%0h", wr_last1, {16'h7000, 8'h5A});
    end
    checks++;
    if (done_cnt1 !== 1) begin
      errors++;
      $error("FAIL len1_done observed=%0h expected=%0h", done_cnt1, 1);
    end
    bus1.I_DMA_RDY = 1'b0;
    tick();

    push_range(11);
    d0 = done_cnt;
    wr2_cnt = 0;
    max_rd_ab = 16'h0;
    bus.I_DMA_RDY = 1'b1;
    ticks(2);
    bus.I_BUSACK_n = 1'b0;
    k = 0;
    while (!(bus.O_AB == 16'h690A && !bus.O_RD_n) && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if ({bus.O_AB, bus.O_RD_n} !== {16'h690A, 1'b0}) begin
      errors++;
      $error("FAIL abort_reach_byte10 observed=%0h expected=%0h", {bus.O_AB, bus.O_RD_n}, {16'h690A, 1'b0});
    end
    bus.I_DMA_RDY = 1'b0;
    wait_rq(1'b1, 50, "abort_release");
    ticks(2);
    bus.I_BUSACK_n = 1'b1;
    ticks(4);
    checks++;
    if (wr2_cnt !== 11) begin
      errors++;
      $error("FAIL abort_writes observed=%0h expected=%0h", wr2_cnt, 11);
    end
    checks++;
    if (max_rd_ab !== 16'h690A) begin
      errors++;
      $error("FAIL abort_last_read observed=%0h expected=%0h", max_rd_ab, 16'h690A);
    end
    checks++;
    if ((done_cnt - d0) !== 0) begin
      errors++;
      $error("FAIL abort_no_done observed=%0h expected=%0h", done_cnt - d0, 0);
    end
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $error("FAIL abort_queue observed=%0h expected=%0h", q.size(), 0);
    end
    checks++;
    if (vec0 !== RST_VEC) begin
      errors++;
      $error("FAIL abort_idle observed=%0h expected=%0h", vec0, RST_VEC);
    end

    d0 = done_cnt;
    wr2_cnt = 0;
    bus.I_DMA_RDY = 1'b1;
    tick();
    checks++;
    if (bus.O_BUSRQ_n !== 1'b0) begin
      errors++;
      $error("FAIL retrig_req observed=%0h expected=%0h", bus.O_BUSRQ_n, 1'b0);
    end
    bus.I_DMA_RDY = 1'b0;
    tick();
    checks++;
    if ({bus.O_BUSRQ_n, bus.O_BUSY} !== 2'b11) begin
      errors++;
      $error("FAIL retrig_req_abort observed=%0h expected=%0h", {bus.O_BUSRQ_n, bus.O_BUSY}, 2'b11);
    end
    bus.I_DMA_RDY = 1'b1;
    tick();
    stayed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.O_BUSRQ_n !== 1'b1 || bus.O_BUSY !== 1'b0) stayed = 1'b0;
    end
    checks++;
    if (stayed !== 1'b1) begin
      errors++;
      $error("FAIL retrig_ignored observed=%0h expected=%0h", stayed, 1'b1);
    end
    checks++;
    if ((done_cnt - d0) !== 0) begin
      errors++;
      $error("FAIL retrig_no_done observed=%0h expected=%0h", done_cnt - d0, 0);
    end
    checks++;
    if (wr2_cnt !== 0) begin
      errors++;
      $error("FAIL retrig_no_writes observed=%0h expected=%0h", wr2_cnt, 0);
    end
    bus.I_DMA_RDY = 1'b0;
    tick();
    bus.I_DMA_RDY = 1'b1;
    tick();
    checks++;
    if (bus.O_BUSRQ_n !== 1'b0) begin
      errors++;
      $error("FAIL retrig_fresh_edge observed=%0h expected=%0h", bus.O_BUSRQ_n, 1'b0);
    end
    bus.I_DMA_RDY = 1'b0;
    ticks(4);
    checks++;
    if (vec0 !== RST_VEC) begin
      errors++;
      $error("FAIL retrig_cleanup observed=%0h expected=%0h", vec0, RST_VEC);
    end

    push_range(101);
    bus.I_DMA_RDY = 1'b1;
    ticks(4);
    bus.I_BUSACK_n = 1'b0;
    k = 0;
    while (!(bus.O_AB == 16'h7064 && !bus.O_WR_n) && k < 1000) begin
      tick();
      k++;
    end
    checks++;
    if ({bus.O_AB, bus.O_WR_n} !== {16'h7064, 1'b0}) begin
      errors++;
      $error("FAIL reset_reach_wr2_100 observed=%0h expected=%0h", {bus.O_AB, bus.O_WR_n}, {16'h7064, 1'b0});
    end
    rst = 1'b1;
    bus.I_DMA_RDY = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (vec0 !== RST_VEC) begin
      errors++;
      $error("FAIL reset_mid_outputs observed=%0h expected=%0h", vec0, RST_VEC);
    end
    bus.I_BUSACK_n = 1'b1;
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $error("FAIL reset_mid_queue observed=%0h expected=%0h", q.size(), 0);
    end
    bus.I_DMA_RDY = 1'b1;
    tick();
    checks++;
    if (bus.O_BUSRQ_n !== 1'b1) begin
      errors++;
      $error("FAIL reset_wins_rdy observed=%0h expected=%0h", bus.O_BUSRQ_n, 1'b1);
    end
    rst = 1'b0;
    wr2_cnt = 0;
    push_range(384);
    tick();
    checks++;
    if (bus.O_BUSRQ_n !== 1'b0) begin
      errors++;
      $error("FAIL restart_busrq observed=%0h expected=%0h", bus.O_BUSRQ_n, 1'b0);
    end
    ticks(3);
    bus.I_BUSACK_n = 1'b0;
    tick();
    checks++;
    if ({bus.O_RD_n, bus.O_AB} !== {1'b0, 16'h6900}) begin
      errors++;
      $error("FAIL restart_index0 observed=%0h expected=%0h", {bus.O_RD_n, bus.O_AB}, {1'b0, 16'h6900});
    end
    wait_rq(1'b1, 2000, "restart_release");
    ticks(2);
    bus.I_BUSACK_n = 1'b1;
    ticks(4);
    checks++;
    if (wr2_cnt !== 384) begin
      errors++;
      $error("FAIL restart_writes observed=%0h expected=%0h", wr2_cnt, 384);
    end
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $error("FAIL restart_queue observed=%0h expected=%0h", q.size(), 0);
    end
    bus.I_DMA_RDY = 1'b0;
    tick();

    quarter = 1'b1;
    ticks(2);
    full_transfer("quarter");
    quarter = 1'b0;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
